dlx_imem: RTL
=============

# dlx_imem

Instruction memory for the DLX core: it supplies the `IIn` word that the core requests on `IAddr`. It is loaded over a byte-serial port after reset and holds the core in reset (`CpuHold`) until loading completes. It then serves registered fetches, one word per cycle. Misaligned, out-of-range and unloaded addresses return a NOP word.

## Interface
- `DEPTH`, 26: number of 32-bit instruction words.
- `NOP_WORD`, 32'h0000_0000: word returned for invalid fetches and during load.
- `CW`, 5: width of `LdCount`; it must hold values 0..`DEPTH`.

- `PHI1`  in  1  system clock; all state changes on the rising edge.
- `MRST`  in  1  reset, synchronous, active-high.
- `LdValid`  in  1  loader byte valid.
- `LdData`  in  8  loader byte.
- `LdLast`  in  1  marks the final byte of the program; qualified by `LdValid`.
- `LdReady`  out  1  loader byte accepted this cycle when `LdValid` is also high.
- `IAddr`  in  32  byte address from the core.
- `IRead`  in  1  fetch request.
- `IIn`  out  32  fetched instruction (registered).
- `IValid`  out  1  `IIn` was updated by a fetch on the previous edge.
- `CpuHold`  out  1  high while loading; drives the core's reset.
- `LdCount`  out  `CW`  number of words written.
- `LdOvf`  out  1  sticky flag: bytes arrived beyond `DEPTH` words.

## Operation
- Storage: `DEPTH` × 32 register array. It is not cleared by reset. Words at index ≥ `LdCount` are unreadable and return `NOP_WORD`.
- State machine, two states: LOAD and RUN.
  - `MRST`=1 forces LOAD on the next edge.
  - LOAD → RUN on the edge that accepts a byte with `LdLast`=1.
  - RUN is exited only by `MRST`.
- Reset values: state LOAD, `IIn`=`NOP_WORD`, `IValid`=0, `LdReady`=0, `CpuHold`=1, `LdCount`=0, `LdOvf`=0, byte lane counter 0, assembly register 0.
- LOAD:
  - `LdReady`=1 in every cycle except the reset cycle.
  - `CpuHold`=1.
  - `IIn` holds `NOP_WORD`, `IValid`=0, and `IRead` is ignored.
- Byte assembly is big-endian: byte lane 0 → bits 31:24, lane 3 → bits 7:0. Each accepted byte advances the lane counter, which wraps 3 → 0.
- Word write: occurs on the lane-3 byte, or on any byte with `LdLast`=1.
  - Unfilled low lanes are written as zero.
  - Target index = `LdCount`; `LdCount` then increments.
  - The assembly register clears after each write.
- Overflow: a word write attempted when `LdCount`=`DEPTH` is dropped. `LdOvf` is set and held until reset, and `LdCount` saturates at `DEPTH`.
  - Bytes keep being accepted after overflow, so the loader never stalls.
  - `LdLast` still moves the block to RUN.
- RUN:
  - `CpuHold`=0 and `LdReady`=0; `LdValid`, `LdData` and `LdLast` are ignored.
- Fetch, evaluated when `IRead`=1 in RUN. Index = `IAddr[31:2]`. The result is registered into `IIn`, with `IValid`=1 on the next cycle.
  - If `IAddr[1:0]`≠0, or index ≥ `LdCount`, or `IAddr[31:2]` ≥ `DEPTH`: `IIn`←`NOP_WORD`.
  - Otherwise `IIn`←mem[index].
- With `IRead`=0 in RUN: `IIn` holds its last value and `IValid`=0.
- Index comparison is on the full 30-bit `IAddr[31:2]`; there is no aliasing or wrap of high address bits.

## Timing
- Fetch latency: 1 cycle, address sampled at edge N, `IIn` valid after edge N. Throughput is one fetch per cycle.
- Load acceptance: 1 byte per cycle. A byte with `LdValid`·`LdReady` at edge N is written (if it completes a word) at edge N, and is readable by a fetch sampled at edge N+1 or later.
- After the edge accepting `LdLast`, `CpuHold`=0 and `LdReady`=0. A fetch presented in that same following cycle is served.
- Reset mid-load: the partial word is discarded, `LdCount`=0, `LdOvf`=0, and the next byte lands in lane 0 of word 0.
- Reset mid-run: the edge with `MRST`=1 ignores `IRead`. `IIn`=`NOP_WORD` and `IValid`=0 on the following cycle.
- `MRST` and `LdValid` in the same cycle: reset wins and the byte is not accepted.

## Test plan
- Load bytes 20,21,00,01,00,22,18,20 (`LdLast` on the last byte), then fetch `IAddr`=0 and then 4 → `IIn`=32'h2021_0001 then 32'h0022_1820, `IValid`=1 each cycle, `LdCount`=2, `CpuHold` falls the cycle after the last byte.
- Load 5 bytes AA,BB,CC,DD,EE with `LdLast` on EE → `LdCount`=2, mem[1]=32'hEE00_0000. A fetch of `IAddr`=8 returns `NOP_WORD`.
- Stream 27 full words (108 bytes), `LdLast` on the final byte → `LdOvf`=1, `LdCount`=26, block enters RUN, mem[25] holds word 26 (the 26th word streamed).
- After a 2-word load: fetch `IAddr`=2 (misaligned), `IAddr`=104 (index 26) and `IAddr`=32'h8000_0000 → each returns `NOP_WORD` with `IValid`=1.
- Assert `MRST` after 6 bytes of a load, then load 4 bytes 01,02,03,04 with `LdLast` → `LdCount`=1, fetch of 0 returns 32'h0102_0304.
- In RUN, fetch 0, then hold `IRead`=0 for 3 cycles → `IIn` unchanged, `IValid`=0 for those 3 cycles.

Source files
------------

// File: rtl/dlx_imem_if.sv
// Loader and fetch bus between the DLX core/loader side and the instruction memory.
// The master drives loader bytes and fetch requests, and the slave returns data and load status.
interface dlx_imem_if #(
  parameter int CW = 5
);
  logic          LdValid;
  logic [7:0]    LdData;
  logic          LdLast;
  logic          LdReady;
  logic [31:0]   IAddr;
  logic          IRead;
  logic [31:0]   IIn;
  logic          IValid;
  logic          CpuHold;
  logic [CW-1:0] LdCount;
  logic          LdOvf;

  modport master (
    output LdValid, LdData, LdLast, IAddr, IRead,
    input  LdReady, IIn, IValid, CpuHold, LdCount, LdOvf
  );

  modport slave (
    input  LdValid, LdData, LdLast, IAddr, IRead,
    output LdReady, IIn, IValid, CpuHold, LdCount, LdOvf
  );
endinterface

// File: rtl/dlx_imem.sv
// DLX instruction memory: byte-serial big-endian loader that holds the core in reset,
// then serves registered one-cycle word fetches. Invalid fetches return NOP_WORD.
module dlx_imem #(
  parameter int          DEPTH    = 26,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CW       = 5
) (
  input  logic       PHI1,
  input  logic       MRST,
  dlx_imem_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_LOAD, ST_RUN} state_e;

  state_e         state_q;
  logic [31:0]    mem_q [DEPTH];
  logic [31:0]    asm_q, asm_d;
  logic [1:0]     lane_q;
  logic [CW-1:0]  ld_count_q;
  logic           ld_ovf_q;
  logic           ld_ready_q;
  logic           cpu_hold_q;
  logic [31:0]    iin_q;
  logic           ivalid_q;

  logic           accept;
  logic           word_done;
  logic           full;
  logic           wr_en;
  logic [29:0]    f_idx;
  logic           f_hit;
  logic [31:0]    rd_word;

  always_comb begin
    accept    = bus.LdValid && ld_ready_q && (state_q == ST_LOAD) && !MRST;
    word_done = accept && ((lane_q == 2'd3) || bus.LdLast);
    full      = (ld_count_q == CW'(DEPTH));
    wr_en     = word_done && !full;

    // Big-endian lanes; lanes not yet filled stay zero from the cleared assembly register.
    asm_d = asm_q;
    case (lane_q)
      2'd0:    asm_d[31:24] = bus.LdData;
      2'd1:    asm_d[23:16] = bus.LdData;
      2'd2:    asm_d[15:8]  = bus.LdData;
      default: asm_d[7:0]   = bus.LdData;
    endcase

    f_idx   = bus.IAddr[31:2];
    f_hit   = (bus.IAddr[1:0] == 2'b00) && (f_idx < 30'(ld_count_q)) && (f_idx < 30'(DEPTH));
    rd_word = mem_q[AW'(f_idx)];
  end

  // NOTE: the storage array has no reset; only words below LdCount are ever readable,
  // so stale contents are never visible and the array maps to plain flops/RAM.
  always_ff @(posedge PHI1) begin
    if (wr_en) begin
      mem_q[AW'(ld_count_q)] <= asm_d;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge PHI1) begin
    if (MRST) begin
      state_q    <= ST_LOAD;
      iin_q      <= NOP_WORD;
      ivalid_q   <= 1'b0;
      ld_ready_q <= 1'b0;
      cpu_hold_q <= 1'b1;
      ld_count_q <= '0;
      ld_ovf_q   <= 1'b0;
      lane_q     <= 2'd0;
      asm_q      <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          iin_q      <= NOP_WORD;
          ivalid_q   <= 1'b0;
          cpu_hold_q <= 1'b1;
          ld_ready_q <= 1'b1;
          if (accept) begin
            if (word_done) begin
              asm_q  <= '0;
              lane_q <= 2'd0;
              if (full) ld_ovf_q   <= 1'b1;
              else      ld_count_q <= ld_count_q + CW'(1);
            end else begin
              asm_q  <= asm_d;
              lane_q <= lane_q + 2'd1;
            end
            if (bus.LdLast) begin
              state_q    <= ST_RUN;
              ld_ready_q <= 1'b0;
              cpu_hold_q <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          ld_ready_q <= 1'b0;
          cpu_hold_q <= 1'b0;
          ivalid_q   <= bus.IRead;
          if (bus.IRead) begin
            iin_q <= f_hit ? rd_word : NOP_WORD;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign bus.LdReady = ld_ready_q;
  assign bus.CpuHold = cpu_hold_q;
  assign bus.LdCount = ld_count_q;
  assign bus.LdOvf   = ld_ovf_q;
  assign bus.IIn     = iin_q;
  assign bus.IValid  = ivalid_q;
endmodule
